// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    CHK,
    RUN,
    ERR
  } state_e;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_W          = 16;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;

  // Word count carried by the two header bytes, low byte first on the wire.
  function automatic logic [HDR_W-1:0] hdr_count(input logic [BYTE_W-1:0] hi,
                                                 input logic [BYTE_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // Loader side
  modport master (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  // Stream source / memory side
  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader_byte_packer.sv
// byte_packer: assembles four little-endian bytes into one 32-bit word.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  logic [1:0]  cnt;
  logic [23:0] shift;

  // Byte counter and right-shifting assembly of the first three bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 2'd0;
      shift <= 24'd0;
    end else if (clear) begin
      cnt   <= 2'd0;
      shift <= 24'd0;
    end else if (byte_en) begin
      cnt   <= cnt + 2'd1;
      shift <= {byte_in, shift[23:8]};
    end
  end

  // The fourth byte completes the word in the same cycle it arrives.
  always_comb begin
    word_valid_c = byte_en && (cnt == 2'(BYTES_PER_WORD - 1));
    word_c       = {byte_in, shift};
  end

endmodule

// File: rtl/program_loader.sv
// program_loader: boots the core from a length-prefixed byte stream.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic             clk,
  input  logic             rst,
  program_loader_if.master bus,
  input  logic             reload,
  output logic             core_rst,
  output logic             done,
  output logic             error
);

  state_e            state;
  logic [BYTE_W-1:0] hdr_lo;
  logic [HDR_W-1:0]  n_words;
  logic [HDR_W-1:0]  word_cnt;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  logic              accept_c;
  logic              restart_c;
  logic              last_word_c;
  logic [HDR_W-1:0]  hdr_n_c;
  logic              word_valid_c;
  logic [WORD_W-1:0] word_c;

  // Handshake, header decode and end-of-image detection.
  always_comb begin
    accept_c    = bus.in_valid && bus.in_ready;
    restart_c   = reload && ((state == RUN) || (state == ERR));
    last_word_c = (word_cnt + 16'd1) == n_words;
    hdr_n_c     = hdr_count(bus.in_data, hdr_lo);
  end

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst),
    .clear        (restart_c),
    .byte_en      (accept_c && (state == DATA)),
    .byte_in      (bus.in_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // Load FSM with registered handshake, memory-write and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= HDR_LO;
      hdr_lo        <= '0;
      n_words       <= '0;
      word_cnt      <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      core_rst      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        HDR_LO: begin
          bus.in_ready <= 1'b1;
          if (accept_c) begin
            hdr_lo <= bus.in_data;
            state  <= HDR_HI;
          end
        end

        HDR_HI: begin
          if (accept_c) begin
            n_words <= hdr_n_c;
            if (hdr_n_c > 16'(MAX_WORDS)) begin
              bus.in_ready <= 1'b0;
              state        <= ERR;
            end else if (hdr_n_c == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state        <= CHK;
`else
              bus.in_ready <= 1'b0;
              state        <= RUN;
`endif
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
`ifdef LOADER_CHECKSUM_EN
          if (accept_c) begin
            csum <= csum ^ bus.in_data;
          end
`endif
          if (word_valid_c) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ADDR_W'(word_cnt);
            bus.mem_wdata <= word_c;
            word_cnt      <= word_cnt + 16'd1;
            if (last_word_c) begin
`ifdef LOADER_CHECKSUM_EN
              state        <= CHK;
`else
              bus.in_ready <= 1'b0;
              state        <= RUN;
`endif
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (accept_c) begin
            bus.in_ready <= 1'b0;
            state        <= (csum == bus.in_data) ? RUN : ERR;
          end
        end
`endif

        RUN, ERR: begin
          if (restart_c) begin
            state        <= HDR_LO;
            bus.in_ready <= 1'b1;
            word_cnt     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
            core_rst     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
          end else if (state == RUN) begin
            // One cycle after the last write, so release never coincides with it.
            core_rst <= 1'b0;
            done     <= 1'b1;
          end else begin
            error <= 1'b1;
          end
        end

        default: begin
          state        <= HDR_LO;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard.
module tb_program_loader;

  logic clk = 1'b0;
  logic rst;
  logic reload;
  logic core_rst;
  logic done;
  logic error;

  program_loader_if #(.ADDR_W(8)) bus();

  program_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .reload   (reload),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb[$];
  logic [31:0] words[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.mem_we === 1'b1) begin
      check("sb_pending", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) check("mem_write", {24'd0, bus.mem_addr, bus.mem_wdata}, sb.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget = 0;
    bit acc = 1'b0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    do begin
      acc = bus.in_ready;
      @(posedge clk); #1;
      budget++;
    end while (!acc && budget < 200);
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
  endtask

  // Header, n words from 'words', optional checksum (xor'ed with chk_flip).
  task automatic load_image(input logic [15:0] n, input logic [7:0] chk_flip, input bit gaps);
    logic [7:0]  cs = 8'h00;
    logic [31:0] w;
    logic [7:0]  b;
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    for (int i = 0; i < int'(n); i++) begin
      w = words[i];
      sb.push_back({24'd0, 8'(i), w});
      for (int j = 0; j < 4; j++) begin
        b  = w[8*j +: 8];
        cs = cs ^ b;
        send_byte(b, gaps);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs ^ chk_flip, gaps);
`else
    if (chk_flip != 8'h00) cs = cs ^ chk_flip;
`endif
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_reload(input string tag);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_core_rst"}, 64'(core_rst), 64'd1);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
  endtask

  task automatic expect_run(input string tag);
    check({tag, "_held"}, 64'(core_rst), 64'd1);
    check({tag, "_not_done_yet"}, 64'(done), 64'd0);
    @(posedge clk); #1;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_core_rst"}, 64'(core_rst), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
    check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({tag, "_core_rst"}, 64'(core_rst), 64'd1);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b0;
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    words        = {32'h00500093, 32'h00A00113};

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");

    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 64'(bus.in_ready), 64'd1);

    // Full-rate image
    load_image(16'd2, 8'h00, 1'b0);
    expect_run("full_rate");

    // Bytes offered after completion must not be taken
    bus.in_data  = 8'hFF;
    bus.in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("run_ignores_stream", 64'(bus.in_ready), 64'd0);
    check("run_stays_done", 64'(done), 64'd1);
    bus.in_valid = 1'b0;

    // Same image with random valid gaps
    pulse_reload("reload_gaps");
    load_image(16'd2, 8'h00, 1'b1);
    expect_run("gaps");

    // Oversized header
    pulse_reload("reload_big");
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("big_error", 64'(error), 64'd1);
    check("big_core_rst", 64'(core_rst), 64'd1);
    check("big_done", 64'(done), 64'd0);
    check("big_ready", 64'(bus.in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("big_error_holds", 64'(error), 64'd1);

`ifdef LOADER_CHECKSUM_EN
    // Corrupted checksum then a clean retry
    pulse_reload("reload_badchk");
    load_image(16'd2, 8'h01, 1'b0);
    @(posedge clk); #1;
    check("badchk_error", 64'(error), 64'd1);
    check("badchk_core_rst", 64'(core_rst), 64'd1);
    check("badchk_done", 64'(done), 64'd0);
    pulse_reload("reload_goodchk");
    load_image(16'd2, 8'h00, 1'b0);
    expect_run("goodchk");
`endif

    // Empty image
    pulse_reload("reload_empty");
    load_image(16'd0, 8'h00, 1'b0);
    expect_run("empty");

    // Reset in the middle of a load (first word already written)
    pulse_reload("reload_partial");
    sb.push_back({24'd0, 8'd0, 32'h00500093});
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h50, 1'b0);
    send_byte(8'h00, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    load_image(16'd2, 8'h00, 1'b0);
    expect_run("after_reset");

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
